// File: rtl/sram_arbiter.sv
// Shares one sram_control port between fetch and data memory; data wins, fetch forced after MAX_D_GRANTS.
// Latency 5 cycles req-to-ack (IDLE, BUSY x3, RELEASE); requesters stall, holding their request, until their ack.
`ifndef MEM_LW
`define MEM_LW 4'd1
`endif

module sram_arbiter #(
   parameter logic [3:0] IF_OP        = `MEM_LW,
   parameter int         MAX_D_GRANTS = 4,
   parameter int         TIMEOUT      = 16
) (
   input  logic        clk50,
   input  logic        rst_n,
   input  logic        if_req_i,
   input  logic [19:0] if_addr_i,
   output logic [31:0] if_rdata_o,
   output logic        if_ack_o,
   output logic        if_stall_o,
   input  logic        mem_req_i,
   input  logic [3:0]  mem_op_i,
   input  logic [19:0] mem_addr_i,
   input  logic [31:0] mem_wdata_i,
   output logic [31:0] mem_rdata_o,
   output logic        mem_ack_o,
   output logic        mem_stall_o,
   output logic [3:0]  ram_op_o,
   output logic [19:0] ram_addr_o,
   output logic [31:0] ram_wdata_o,
   input  logic [31:0] ram_rdata_i,
   input  logic        ram_success_i,
   output logic        err_o
);

   localparam int DW = $clog2(MAX_D_GRANTS + 1);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [DW-1:0] DCNT_MAX  = DW'(MAX_D_GRANTS);
   localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RELEASE} state_t;

   state_t        state_q, state_d;
   logic          owner_mem_q, owner_mem_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [3:0]    ram_op_d;
   logic [19:0]   ram_addr_d;
   logic [31:0]   ram_wdata_d;
   logic [31:0]   if_rdata_d, mem_rdata_d;
   logic          if_ack_d, mem_ack_d, err_d;
   logic          mem_vld, if_guard;

   // An op code of zero means "no operation" and must never reach the controller.
   assign mem_vld  = mem_req_i & (mem_op_i != 4'd0);
   assign if_guard = if_req_i & (dcnt_q == DCNT_MAX);

   assign if_stall_o  = if_req_i & ~if_ack_o;
   assign mem_stall_o = mem_req_i & ~mem_ack_o;

   always_comb begin
      state_d     = state_q;
      owner_mem_d = owner_mem_q;
      dcnt_d      = dcnt_q;
      tcnt_d      = tcnt_q;
      ram_op_d    = ram_op_o;
      ram_addr_d  = ram_addr_o;
      ram_wdata_d = ram_wdata_o;
      if_rdata_d  = if_rdata_o;
      mem_rdata_d = mem_rdata_o;
      if_ack_d    = 1'b0;
      mem_ack_d   = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_vld && !if_guard) begin
               owner_mem_d = 1'b1;
               ram_op_d    = mem_op_i;
               ram_addr_d  = mem_addr_i;
               ram_wdata_d = mem_wdata_i;
               tcnt_d      = '0;
               state_d     = ST_BUSY;
               if (!if_req_i)
                  dcnt_d = '0;
               else if (dcnt_q != DCNT_MAX)
                  dcnt_d = dcnt_q + DW'(1);
            end else if (if_req_i) begin
               owner_mem_d = 1'b0;
               ram_op_d    = IF_OP;
               ram_addr_d  = if_addr_i;
               ram_wdata_d = '0;
               tcnt_d      = '0;
               dcnt_d      = '0;
               state_d     = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (ram_success_i) begin
               if (owner_mem_q) begin
                  mem_rdata_d = ram_rdata_i;
                  mem_ack_d   = 1'b1;
               end else begin
                  if_rdata_d = ram_rdata_i;
                  if_ack_d   = 1'b1;
               end
               ram_op_d = '0;
               state_d  = ST_RELEASE;
            end else if (tcnt_q == TCNT_LAST) begin
               // Abort still completes the handshake so the owner does not hang.
               if (owner_mem_q) begin
                  mem_rdata_d = '0;
                  mem_ack_d   = 1'b1;
               end else begin
                  if_rdata_d = '0;
                  if_ack_d   = 1'b1;
               end
               err_d    = 1'b1;
               ram_op_d = '0;
               state_d  = ST_RELEASE;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         ST_RELEASE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         owner_mem_q <= 1'b0;
         dcnt_q      <= '0;
         tcnt_q      <= '0;
         ram_op_o    <= '0;
         ram_addr_o  <= '0;
         ram_wdata_o <= '0;
         if_rdata_o  <= '0;
         mem_rdata_o <= '0;
         if_ack_o    <= 1'b0;
         mem_ack_o   <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_mem_q <= owner_mem_d;
         dcnt_q      <= dcnt_d;
         tcnt_q      <= tcnt_d;
         ram_op_o    <= ram_op_d;
         ram_addr_o  <= ram_addr_d;
         ram_wdata_o <= ram_wdata_d;
         if_rdata_o  <= if_rdata_d;
         mem_rdata_o <= mem_rdata_d;
         if_ack_o    <= if_ack_d;
         mem_ack_o   <= mem_ack_d;
         err_o       <= err_d;
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transaction-level model of the arbitration rules plus an SRAM responder
// owned by the bench; directed scenarios first, then randomized traffic.
module tb_sram_arbiter;
   localparam logic [3:0] OP_LW = 4'd1;
   localparam logic [3:0] OP_SW = 4'd2;
   localparam logic [3:0] OP_LB = 4'd3;
   localparam int MAXD = 4;
   localparam int TMO  = 16;

   logic        clk50, rst_n;
   logic        if_req_i, if_ack_o, if_stall_o;
   logic [19:0] if_addr_i;
   logic [31:0] if_rdata_o;
   logic        mem_req_i, mem_ack_o, mem_stall_o;
   logic [3:0]  mem_op_i;
   logic [19:0] mem_addr_i;
   logic [31:0] mem_wdata_i, mem_rdata_o;
   logic [3:0]  ram_op_o;
   logic [19:0] ram_addr_o;
   logic [31:0] ram_wdata_o, ram_rdata_i;
   logic        ram_success_i, err_o;

   sram_arbiter #(.IF_OP(OP_LW), .MAX_D_GRANTS(MAXD), .TIMEOUT(TMO)) dut (
      .clk50(clk50), .rst_n(rst_n),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
      .if_ack_o(if_ack_o), .if_stall_o(if_stall_o),
      .mem_req_i(mem_req_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
      .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
      .mem_stall_o(mem_stall_o), .ram_op_o(ram_op_o), .ram_addr_o(ram_addr_o),
      .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
      .ram_success_i(ram_success_i), .err_o(err_o)
   );

   initial begin
      clk50 = 1'b0;
      forever #10 clk50 = ~clk50;
   end

   int nvec = 0;
   int nbad = 0;
   int cyc  = 0;

   // One outstanding access: where it started, when it releases (-1 = still busy), its outcome.
   bit          have_acc, acc_mem, acc_err;
   logic [3:0]  acc_op;
   logic [19:0] acc_addr;
   logic [31:0] acc_wdata, acc_rdata;
   int          acc_start, acc_end, acc_lat, streak;

   bit          e_if_ack, e_mem_ack, e_err, e_if_stall, e_mem_stall;
   bit          prev_if_ack, prev_mem_ack;
   logic [3:0]  e_op;
   logic [19:0] e_addr;
   logic [31:0] e_wdata, e_rdata;

   bit          rand_en, hold_if, hold_mem;
   int          fix_lat = 2;
   int          junk_life;
   logic [31:0] sram [logic [19:0]];
   int          lat_tab [10] = '{1, 2, 2, 2, 2, 3, 4, 6, 15, 99};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [19:0] rnd_addr();
      return 20'h00020 + 20'($urandom_range(0, 15));
   endfunction

   function automatic logic [31:0] sram_rd(input logic [19:0] a);
      if (sram.exists(a)) return sram[a];
      return {12'hC0D, a};
   endfunction

   function automatic bit owner_busy(input bit m);
      return have_acc && (acc_mem == m) && (acc_end != cyc);
   endfunction

   task automatic open_acc(input bit m, input logic [3:0] op, input logic [19:0] a, input logic [31:0] wd);
      have_acc  = 1'b1;
      acc_mem   = m;
      acc_op    = op;
      acc_addr  = a;
      acc_wdata = wd;
      acc_start = cyc;
      acc_end   = -1;
      acc_lat   = (fix_lat >= 0) ? fix_lat : lat_tab[$urandom_range(0, 9)];
   endtask

   // Advance the model across the clock edge using the inputs of the cycle just ended.
   task automatic model_edge();
      if (!have_acc) begin
         if (mem_req_i && mem_op_i != 4'd0 && !(if_req_i && streak == MAXD)) begin
            streak = if_req_i ? ((streak < MAXD) ? streak + 1 : streak) : 0;
            open_acc(1'b1, mem_op_i, mem_addr_i, mem_wdata_i);
         end else if (if_req_i) begin
            streak = 0;
            open_acc(1'b0, OP_LW, if_addr_i, 32'h0);
         end
      end else if (acc_end == cyc - 1) begin
         have_acc = 1'b0;
      end else if (acc_end < 0) begin
         if (ram_success_i) begin
            acc_end = cyc; acc_err = 1'b0; acc_rdata = ram_rdata_i;
         end else if (cyc - 1 - acc_start == TMO - 1) begin
            acc_end = cyc; acc_err = 1'b1; acc_rdata = 32'h0;
         end
      end
      e_op = 4'd0; e_addr = 20'h0; e_wdata = 32'h0; e_rdata = 32'h0;
      e_if_ack = 1'b0; e_mem_ack = 1'b0; e_err = 1'b0;
      if (have_acc) begin
         if (acc_end == cyc) begin
            e_err   = acc_err;
            e_rdata = acc_rdata;
            if (acc_mem) e_mem_ack = 1'b1; else e_if_ack = 1'b1;
         end else begin
            e_op = acc_op; e_addr = acc_addr; e_wdata = acc_wdata;
         end
      end
   endtask

   task automatic new_mem(input bit allow0);
      int r;
      r = $urandom_range(allow0 ? 0 : 1, 9);
      mem_req_i   = 1'b1;
      mem_addr_i  = rnd_addr();
      mem_wdata_i = $urandom();
      if (r == 0) begin
         mem_op_i  = 4'd0;
         junk_life = $urandom_range(1, 5);
      end else if (r <= 4) mem_op_i = OP_SW;
      else if (r <= 8)     mem_op_i = OP_LW;
      else                 mem_op_i = OP_LB;
   endtask

   task automatic drive_requesters();
      if (if_req_i && prev_if_ack) begin
         if (hold_if || (rand_en && $urandom_range(0, 1) == 1)) if_addr_i = rnd_addr();
         else if_req_i = 1'b0;
      end else if (!if_req_i) begin
         if (rand_en && $urandom_range(0, 9) < 3) begin
            if_req_i = 1'b1; if_addr_i = rnd_addr();
         end
      end else if (rand_en && owner_busy(1'b0) && $urandom_range(0, 1) == 1) begin
         if_addr_i = rnd_addr();
      end
      if (mem_req_i && mem_op_i == 4'd0) begin
         junk_life--;
         if (junk_life <= 0) mem_req_i = 1'b0;
      end else if (mem_req_i && prev_mem_ack) begin
         if (hold_mem || (rand_en && $urandom_range(0, 1) == 1)) new_mem(rand_en);
         else mem_req_i = 1'b0;
      end else if (!mem_req_i) begin
         if (rand_en && $urandom_range(0, 9) < 3) new_mem(1'b1);
      end else if (rand_en && owner_busy(1'b1) && $urandom_range(0, 1) == 1) begin
         mem_addr_i = rnd_addr(); mem_wdata_i = $urandom();
      end
   endtask

   task automatic drive_ram();
      ram_success_i = 1'b0;
      ram_rdata_i   = $urandom();
      if (have_acc && acc_end < 0 && cyc - acc_start == acc_lat) begin
         ram_success_i = 1'b1;
         if (acc_op == OP_SW) sram[acc_addr] = acc_wdata;
         else ram_rdata_i = sram_rd(acc_addr);
      end
   endtask

   task automatic cycle();
      @(posedge clk50);
      #1;
      cyc++;
      prev_if_ack  = e_if_ack;
      prev_mem_ack = e_mem_ack;
      model_edge();
      drive_requesters();
      drive_ram();
      e_if_stall  = if_req_i & ~e_if_ack;
      e_mem_stall = mem_req_i & ~e_mem_ack;
      @(negedge clk50);
      chk("if_ack", if_ack_o, e_if_ack);
      chk("mem_ack", mem_ack_o, e_mem_ack);
      chk("err", err_o, e_err);
      chk("ram_op", ram_op_o, e_op);
      chk("if_stall", if_stall_o, e_if_stall);
      chk("mem_stall", mem_stall_o, e_mem_stall);
      if (e_op != 4'd0) begin
         chk("ram_addr", ram_addr_o, e_addr);
         chk("ram_wdata", ram_wdata_o, e_wdata);
      end
      if (e_if_ack)  chk("if_rdata", if_rdata_o, e_rdata);
      if (e_mem_ack) chk("mem_rdata", mem_rdata_o, e_rdata);
   endtask

   task automatic wait_ack(input bit for_mem, output int n);
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         cycle();
         if ((for_mem ? mem_ack_o : if_ack_o) === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      if_req_i = 1'b0; if_addr_i = 20'h0;
      mem_req_i = 1'b0; mem_op_i = 4'd0; mem_addr_i = 20'h0; mem_wdata_i = 32'h0;
      ram_success_i = 1'b0; ram_rdata_i = 32'h0;
      #1;
      chk("rst_ram_op", ram_op_o, 4'd0);
      chk("rst_ram_addr", ram_addr_o, 20'h0);
      chk("rst_ram_wdata", ram_wdata_o, 32'h0);
      chk("rst_if_rdata", if_rdata_o, 32'h0);
      chk("rst_mem_rdata", mem_rdata_o, 32'h0);
      chk("rst_acks", {if_ack_o, mem_ack_o, err_o}, 3'b000);
      chk("rst_stalls", {if_stall_o, mem_stall_o}, 2'b00);
      have_acc = 1'b0; streak = 0;
      e_if_ack = 1'b0; e_mem_ack = 1'b0; e_err = 1'b0;
      repeat (2) @(posedge clk50);
      @(negedge clk50);
      rst_n = 1'b1;
   endtask

   initial begin
      int n, nack;
      logic [9:0] order;
      rst_n = 1'b1;
      if_req_i = 1'b0; if_addr_i = 20'h0;
      mem_req_i = 1'b0; mem_op_i = 4'd0; mem_addr_i = 20'h0; mem_wdata_i = 32'h0;
      ram_success_i = 1'b0; ram_rdata_i = 32'h0;
      sram[20'h00010] = 32'h2402_0005;
      #3;
      do_reset();
      repeat (2) cycle();

      // Fetch of a known word at nominal latency.
      if_req_i = 1'b1; if_addr_i = 20'h00010;
      cycle();
      chk("if_busy_op", ram_op_o, OP_LW);
      chk("if_busy_addr", ram_addr_o, 20'h00010);
      wait_ack(1'b0, n);
      chk("if_lat_rest", n, 3);
      chk("if_word", if_rdata_o, 32'h2402_0005);
      cycle();

      // Store then load back the same word.
      mem_req_i = 1'b1; mem_op_i = OP_SW; mem_addr_i = 20'h00020; mem_wdata_i = 32'hDEAD_BEEF;
      wait_ack(1'b1, n);
      chk("sw_lat", n, 4);
      cycle();
      mem_req_i = 1'b1; mem_op_i = OP_LW; mem_addr_i = 20'h00020; mem_wdata_i = 32'h0;
      wait_ack(1'b1, n);
      chk("lw_lat", n, 4);
      chk("lw_word", mem_rdata_o, 32'hDEAD_BEEF);
      cycle();

      // Both requesters held continuously: starvation guard order.
      hold_if = 1'b1; hold_mem = 1'b1;
      if_req_i = 1'b1; if_addr_i = rnd_addr();
      new_mem(1'b0);
      order = '0; nack = 0;
      for (int i = 0; i < 300 && nack < 10; i++) begin
         cycle();
         if (mem_ack_o === 1'b1) begin order = {order[8:0], 1'b1}; nack++; end
         else if (if_ack_o === 1'b1) begin order = {order[8:0], 1'b0}; nack++; end
      end
      chk("grant_count", nack, 10);
      chk("grant_order", order, 10'b1111011110);
      hold_if = 1'b0; hold_mem = 1'b0;
      repeat (20) cycle();

      // Controller never answers: abort after TIMEOUT busy cycles.
      fix_lat = 1000;
      mem_req_i = 1'b1; mem_op_i = OP_LW; mem_addr_i = 20'h00024;
      wait_ack(1'b1, n);
      fix_lat = 2;
      chk("tmo_lat", n, 17);
      chk("tmo_err", err_o, 1'b1);
      chk("tmo_rdata", mem_rdata_o, 32'h0);
      chk("tmo_op_idle", ram_op_o, 4'd0);
      cycle();

      // Reset in the middle of a store drops it silently.
      mem_req_i = 1'b1; mem_op_i = OP_SW; mem_addr_i = 20'h00030; mem_wdata_i = 32'h1234_5678;
      repeat (2) cycle();
      chk("pre_rst_op", ram_op_o, OP_SW);
      do_reset();
      nack = 0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (mem_ack_o === 1'b1) nack++;
      end
      chk("no_ack_after_rst", nack, 0);
      if_req_i = 1'b1; if_addr_i = 20'h00010;
      wait_ack(1'b0, n);
      chk("post_rst_lat", n, 4);
      chk("post_rst_word", if_rdata_o, 32'h2402_0005);

      // New requests from both sides arrive on the release edge: one grant, data first.
      hold_if = 1'b1;
      mem_req_i = 1'b1; mem_op_i = OP_LW; mem_addr_i = 20'h00010;
      cycle();
      hold_if = 1'b0;
      cycle();
      chk("race_op", ram_op_o, OP_LW);
      chk("race_addr", ram_addr_o, 20'h00010);
      wait_ack(1'b1, n);
      chk("race_lat", n, 3);
      chk("race_word", mem_rdata_o, 32'h2402_0005);
      repeat (20) cycle();

      // Randomized traffic with a reset dropped in halfway.
      rand_en = 1'b1; fix_lat = -1;
      for (int i = 0; i < 3000; i++) begin
         cycle();
         if (i == 1500) do_reset();
      end
      rand_en = 1'b0;
      repeat (80) cycle();
      chk("drain_if", if_req_i, 1'b0);
      chk("drain_mem", mem_req_i, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end
endmodule
